bcd_display_scanner: RTL
========================

// Module: bcd_display_scanner
// PURPOSE
//  Downstream consumer of the 8-bit binary-to-BCD converter: takes its 12-bit BCD word
//  {hundreds,tens,ones} and time-multiplexes it onto a 3-digit common-anode 7-segment display.
//  Holds a pending/active value pair so the display only changes on frame boundaries.
//  Includes anti-ghosting blanking at the start of each digit slot.
// PARAMETERS
//  CLK_DIV       50000  clk cycles per digit slot; legal range >= 4
//  BLANK_CYCLES  4      cycles at the start of each slot with all anodes off; legal range 1..CLK_DIV-2
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  bcd_in      in   12  BCD word [11:8]=hundreds, [7:4]=tens, [3:0]=ones
//  bcd_valid   in   1   single-cycle load strobe for bcd_in
//  seg_n       out  7   segments {g,f,e,d,c,b,a}, active-low, registered
//  an_n        out  3   digit anodes [0]=ones, [1]=tens, [2]=hundreds; active-low, registered
//  frame_tick  out  1   1-cycle pulse when the active value is (re)loaded at a frame start
// BEHAVIOUR
//  - Reset (async assert): state=ONES, div_cnt=0, pending=active=12'h000,
//    seg_n=7'h7F, an_n=3'b111, frame_tick=0.
//    Release is synchronous to clk; the first frame displays 000.
//  - div_cnt counts 0..CLK_DIV-1 and wraps. On wrap, FSM advances ONES->TENS->HUNDS->ONES.
//  - Entering ONES from HUNDS (frame boundary): active<=pending; frame_tick=1 for that cycle.
//  - bcd_valid=1: pending<=bcd_in. If it coincides with the frame-boundary cycle,
//    active<=bcd_in directly (bypass), so the new value shows in that frame.
//    Multiple strobes within one frame: the last one wins.
//  - Outputs are registered, 1-cycle latency from div_cnt/state.
//    - While div_cnt<BLANK_CYCLES: an_n=3'b111, seg_n=7'h7F.
//    - Otherwise: an_n = 110 (ONES), 101 (TENS) or 011 (HUNDS); seg_n = decode(active nibble).
//  - Decode (seg_n): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//    Any nibble >9 displays a dash, 0111111 (segment g only).
//  - Frame period = 3*CLK_DIV cycles. No stalls; bcd_valid is never back-pressured.
//  - Reset mid-frame: outputs go blank immediately and the scan restarts at ONES with 000.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - Hundreds digit blanked (an_n[2] held 1, seg_n=7'h7F) when its nibble==0.
//    - Tens digit blanked when hundreds==0 and tens==0.
//    - Ones digit is never blanked. A dash nibble counts as non-zero.
//  LEADING_ZERO_BLANK_EN undefined: all three digits are always shown, leading zeros included.
// TESTING  (CLK_DIV=8, BLANK_CYCLES=2)
//  1. Reset held, then released -> seg_n=7F, an_n=111 for 2 cycles; then an_n=110, seg_n=1000000.
//  2. bcd_in=12'h202 with strobe mid-frame -> from next frame:
//     ONES an_n=110 seg 0100100; TENS an_n=101 seg 1000000; HUNDS an_n=011 seg 0100100.
//  3. bcd_in=12'h1A5 -> TENS slot shows seg_n=0111111 (dash); ONES shows 0010010; HUNDS shows 1111001.
//  4. Strobe 12'h045 in the same cycle as the HUNDS->ONES wrap -> frame_tick=1 that cycle;
//     ONES shows 0010010 in that same frame.
//  5. bcd_in=12'h007:
//     with LEADING_ZERO_BLANK_EN -> HUNDS and TENS slots an_n=111, seg_n=7F; ONES shows 1111000.
//     Without the macro -> 0, 0, 7 are shown.
//  6. Assert rst_n=0 mid-TENS slot -> an_n=111 and seg_n=7F in the same cycle;
//     after release, the 000 frame starts at ONES.

Source files
------------

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexes a 3-digit BCD word onto a common-anode 7-seg display; `LEADING_ZERO_BLANK_EN blanks leading zeros
module bcd_display_scanner #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        bcd_valid,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n,
    output logic        frame_tick
);
    localparam int CW = $clog2(CLK_DIV);
    typedef enum logic [1:0] {ONES, TENS, HUNDS} state_t;
    state_t      state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [11:0] pending_q, pending_d, active_q, active_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic [2:0]  an_n_q, an_n_d;
    logic        wrap, frame_start, hide, blank;
    logic [3:0]  nibble;
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'd0: decode = 7'b1000000;
            4'd1: decode = 7'b1111001;
            4'd2: decode = 7'b0100100;
            4'd3: decode = 7'b0110000;
            4'd4: decode = 7'b0011001;
            4'd5: decode = 7'b0010010;
            4'd6: decode = 7'b0000010;
            4'd7: decode = 7'b1111000;
            4'd8: decode = 7'b0000000;
            4'd9: decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction
    // Slot timing, value hand-off at the frame boundary, and next display drive
    always_comb begin
        wrap        = div_cnt_q == CW'(CLK_DIV - 1);
        frame_start = wrap && state_q == HUNDS;
        div_cnt_d   = wrap ? '0 : div_cnt_q + CW'(1);
        state_d     = !wrap ? state_q : state_q == ONES ? TENS : state_q == TENS ? HUNDS : ONES;
        pending_d   = bcd_valid ? bcd_in : pending_q;
        active_d    = frame_start ? pending_d : active_q;
        nibble      = state_q == ONES ? active_q[3:0] : state_q == TENS ? active_q[7:4] : active_q[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        hide        = (state_q == HUNDS && active_q[11:8] == 4'd0) ||
                      (state_q == TENS && active_q[11:4] == 8'd0);
`else
        hide        = 1'b0;
`endif
        blank       = div_cnt_q < CW'(BLANK_CYCLES) || hide;
        an_n_d      = blank ? 3'b111 : state_q == ONES ? 3'b110 : state_q == TENS ? 3'b101 : 3'b011;
        seg_n_d     = blank ? 7'h7F : decode(nibble);
    end
    // Register scan state, stored values and display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ONES;
            div_cnt_q <= '0;
            pending_q <= 12'h000;
            active_q  <= 12'h000;
            seg_n_q   <= 7'h7F;
            an_n_q    <= 3'b111;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            seg_n_q   <= seg_n_d;
            an_n_q    <= an_n_d;
        end
    end
    assign seg_n      = seg_n_q;
    assign an_n       = an_n_q;
    assign frame_tick = frame_start;
endmodule
